decoder_2_4_stream: RTL and testbench

- Streaming 2-to-4 decoder: the receive-side counterpart of the 4-to-2 encoder.
- Accepts 3-bit encoded words in encoder output format, {valid flag, index[1:0]}, over a valid/ready handshake.
- Decodes each accepted word to a 4-bit one-hot, buffers it in a small FIFO, and presents it on a valid/ready output port.
- Keeps saturating per-line hit counters and an error counter, used by the combinational-circuits bench for loopback checking against the encoder.

---
 rtl/decoder_2_4_stream.sv | 109 ++++++++++
 tb/tb_decoder_2_4_stream.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_2_4_stream.sv
// Streaming 2-to-4 decoder: {valid, index[1:0]} words in, one-hot words out through a FIFO.
// Latency: one cycle from accept into an empty FIFO to out_valid; no combinational in-to-out path.
// Backpressure: in_ready = !rst && !full; no pass-through when full, even with a same-cycle pop.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   en                   decode enable, sampled at acceptance
//   in_valid/in_ready    upstream handshake, in_code = {encoder valid flag, index[1:0]}
//   out_valid/out_ready  downstream handshake, out_onehot = FIFO head (0 when empty)
//   clr_cnt              synchronous clear of all counters (wins over a same-edge accept)
//   hit_cnt              per-line saturating hit counters, line k at [k*CNT_W +: CNT_W]
//   err_cnt              saturating count of accepts with en=1 and in_code[2]=0
module decoder_2_4_stream #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_onehot,
  input  logic               clr_cnt,
  output logic [4*CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Occupancy carries one extra bit so full (== FIFO_DEPTH) and empty (== 0) are distinct.
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] hit_q [4];
  logic [CNT_W-1:0] hit_d [4];
  logic [CNT_W-1:0] err_q, err_d;

  logic       full, empty, push, pop;
  logic [3:0] decoded;

  assign full  = (occ_q == (PW+1)'(FIFO_DEPTH));
  assign empty = (occ_q == '0);

  assign in_ready  = !rst && !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign decoded    = (en && in_code[2]) ? (4'b0001 << in_code[1:0]) : 4'b0000;
  assign out_onehot = out_valid ? mem_q[rd_ptr_q] : 4'b0000;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    hit_d    = hit_q;
    err_d    = err_q;

    // Pointer widths equal log2(depth), so the increment wraps naturally.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   occ_d = occ_q + (PW+1)'(1);
      2'b01:   occ_d = occ_q - (PW+1)'(1);
      default: occ_d = occ_q;
    endcase

    if (clr_cnt) begin
      for (int k = 0; k < 4; k++) hit_d[k] = '0;
      err_d = '0;
    end else if (push && en) begin
      if (in_code[2]) begin
        if (hit_q[in_code[1:0]] != '1) hit_d[in_code[1:0]] = hit_q[in_code[1:0]] + CNT_W'(1);
      end else begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      err_q    <= '0;
      for (int k = 0; k < 4; k++) hit_q[k] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'b0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
      hit_q    <= hit_d;
      if (push) mem_q[wr_ptr_q] <= decoded;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_hit
    assign hit_cnt[k*CNT_W +: CNT_W] = hit_q[k];
  end

  assign err_cnt = err_q;

endmodule

// File: tb/tb_decoder_2_4_stream.sv
module tb_decoder_2_4_stream;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;

  logic               clk;
  logic               rst;
  logic               en;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_code;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_onehot;
  logic               clr_cnt;
  logic [4*CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0]   err_cnt;

  decoder_2_4_stream #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .clr_cnt    (clr_cnt),
    .hit_cnt    (hit_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       en;
    logic [2:0] code;
    logic [3:0] exp_oh;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_code = 3'b000;
    out_ready = 1'b1; clr_cnt = 1'b0;

    vecs[0] = '{1'b1, 3'b100, 4'b0001};
    vecs[1] = '{1'b1, 3'b101, 4'b0010};
    vecs[2] = '{1'b1, 3'b110, 4'b0100};
    vecs[3] = '{1'b1, 3'b111, 4'b1000};
    vecs[4] = '{1'b1, 3'b010, 4'b0000};
    vecs[5] = '{1'b0, 3'b111, 4'b0000};

    // Reset: two cycles
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_onehot", 32'(out_onehot), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven decode, one word per cycle, out_ready=1
    for (int i = 0; i < 6; i++) begin
      en = vecs[i].en; in_code = vecs[i].code; in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_onehot", i), 32'(out_onehot), 32'(vecs[i].exp_oh));
    end
    in_valid = 1'b0; en = 1'b1;
    step();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("decode_hit_cnt", 32'(hit_cnt), 32'h55);
    chk("decode_err_cnt", 32'(err_cnt), 32'd1);

    // Backpressure with depth 2
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    chk("clr_hit", 32'(hit_cnt), 32'd0);
    chk("clr_err", 32'(err_cnt), 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'b101;
    step();
    chk("bp_first_oh", 32'(out_onehot), 32'b0010);
    in_code = 3'b110;
    chk("bp_second_rdy", 32'(in_ready), 32'd1);
    step();
    chk("bp_full_rdy", 32'(in_ready), 32'd0);
    in_code = 3'b111;
    step();
    chk("bp_held_rdy", 32'(in_ready), 32'd0);
    chk("bp_held_oh", 32'(out_onehot), 32'b0010);
    chk("bp_held_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_no_passthru", 32'(in_ready), 32'd0);
    step();
    chk("bp_pop1_oh", 32'(out_onehot), 32'b0100);
    chk("bp_pop1_rdy", 32'(in_ready), 32'd1);
    step();
    chk("bp_pop2_oh", 32'(out_onehot), 32'b1000);
    in_valid = 1'b0;
    step();
    chk("bp_drain_valid", 32'(out_valid), 32'd0);
    chk("bp_hit_cnt", 32'(hit_cnt), 32'h54);

    // Continuous push/pop across pointer wrap
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic [1:0] idx;
      logic [3:0] exp_oh;
      idx = 2'(i % 4);
      exp_oh = 4'b0001 << idx;
      in_valid = 1'b1; in_code = {1'b1, idx};
      #1;
      chk($sformatf("wrap%0d_rdy", i), 32'(in_ready), 32'd1);
      step();
      chk($sformatf("wrap%0d_oh", i), 32'(out_onehot), 32'(exp_oh));
    end
    in_valid = 1'b0;
    step();
    chk("wrap_drain_valid", 32'(out_valid), 32'd0);
    chk("wrap_hit_cnt", 32'(hit_cnt), 32'hAF);

    // Saturation at CNT_W=2, then clear beating a same-edge accept
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    in_valid = 1'b1; in_code = 3'b100;
    for (int i = 0; i < 5; i++) step();
    chk("sat_line0", 32'(hit_cnt[1:0]), 32'd3);
    chk("sat_others", 32'(hit_cnt[7:2]), 32'd0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0; in_valid = 1'b0;
    chk("clr_wins_line0", 32'(hit_cnt[1:0]), 32'd0);
    chk("clr_fifo_kept", 32'({out_valid, out_onehot}), 32'b10001);
    step();
    chk("clr_drain_valid", 32'(out_valid), 32'd0);

    // Reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'b101;
    step();
    in_code = 3'b110;
    step();
    chk("mid_buffered_oh", 32'(out_onehot), 32'b0010);
    in_code = 3'b111;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_oh", 32'(out_onehot), 32'd0);
    chk("mid_rst_hit", 32'(hit_cnt), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_no_stale%0d", i), 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; in_code = 3'b100;
    step();
    in_valid = 1'b0;
    chk("mid_fresh_oh", 32'({out_valid, out_onehot}), 32'b10001);
    step();
    chk("mid_fresh_drain", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
